// File: rtl/mips_alu_md_pkg.sv
// mips_alu_pkg: ALU opcodes, FSM states and opcode helpers shared by the ALU slice
package mips_alu_pkg;
  localparam logic [3:0] ALU_AND   = 4'd0;
  localparam logic [3:0] ALU_OR    = 4'd1;
  localparam logic [3:0] ALU_ADD   = 4'd2;
  localparam logic [3:0] ALU_MULTU = 4'd3;
  localparam logic [3:0] ALU_DIVU  = 4'd4;
  localparam logic [3:0] ALU_SUB   = 4'd6;
  localparam logic [3:0] ALU_SLT   = 4'd7;
  localparam logic [3:0] ALU_MFHI  = 4'd8;
  localparam logic [3:0] ALU_MFLO  = 4'd9;
  localparam logic [3:0] ALU_NOR   = 4'd12;
  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV} state_t;
  function automatic logic is_muldiv(input logic [3:0] c);
    return c == ALU_MULTU || c == ALU_DIVU;
  endfunction
endpackage

// File: rtl/mips_alu_md_if.sv
// mips_alu_md_if: request/result bus between the EX-stage controller and the ALU
interface mips_alu_md_if #(parameter int WIDTH = 32) ();
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       ALUctl;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             out_valid;
  logic [WIDTH-1:0] ALUOut;
  logic             Zero;
  logic             Overflow;
  logic             busy;
  modport master (output in_valid, ALUctl, A, B, input in_ready, out_valid, ALUOut, Zero, Overflow, busy);
  modport slave  (input in_valid, ALUctl, A, B, output in_ready, out_valid, ALUOut, Zero, Overflow, busy);
endinterface

// File: rtl/mips_alu_md_muldiv.sv
// mips_muldiv_iter: one-bit-per-cycle unsigned shift-add multiplier / restoring divider
module mips_muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH) + 1;
  logic             active;
  logic             is_div;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hr;
  logic [WIDTH-1:0] lr;
  logic [WIDTH-1:0] br;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   sh;
  logic [WIDTH:0]   diff;
  logic             ge;
  // next {hi,lo}: multiply adds into hi and shifts right; divide shifts left and trial-subtracts
  always_comb begin
    sum  = {1'b0, hr} + (lr[0] ? {1'b0, br} : '0);
    sh   = {hr, lr[WIDTH-1]};
    diff = sh - {1'b0, br};
    ge   = !diff[WIDTH];
    hi   = is_div ? (ge ? diff[WIDTH-1:0] : sh[WIDTH-1:0]) : sum[WIDTH:1];
    lo   = is_div ? {lr[WIDTH-2:0], ge} : {sum[0], lr[WIDTH-1:1]};
  end
  assign done = active && cnt == '0;
  // operand latch on start, then one iteration per cycle down to count 0
  always_ff @(posedge clk) begin
    if (rst) begin
      active <= 1'b0;
      is_div <= 1'b0;
      cnt    <= '0;
      hr     <= '0;
      lr     <= '0;
      br     <= '0;
    end else if (start) begin
      active <= 1'b1;
      is_div <= div;
      cnt    <= CW'(WIDTH - 1);
      hr     <= '0;
      lr     <= div ? a : b;
      br     <= div ? b : a;
    end else if (active) begin
      hr     <= hi;
      lr     <= lo;
      cnt    <= cnt - CW'(1);
      active <= !done;
    end
  end
endmodule

// File: rtl/mips_alu_md.sv
// mips_alu_md: registered MIPS ALU with iterative MULTU/DIVU and HI/LO registers
module mips_alu_md
  import mips_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic          clk,
  input logic          reset,
  mips_alu_md_if.slave bus
);
  state_t           state;
  state_t           nxt;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] dif;
  logic [WIDTH-1:0] md_hi;
  logic [WIDTH-1:0] md_lo;
  logic             ovf;
  logic             accept;
  logic             start;
  logic             md_done;
  assign bus.in_ready = state == ST_IDLE && !reset;
  assign bus.busy     = state != ST_IDLE;
  assign accept       = bus.in_valid && bus.in_ready;
  assign start        = accept && is_muldiv(bus.ALUctl);
  mips_muldiv_iter #(.WIDTH(WIDTH)) u_md (
    .clk   (clk),
    .rst   (reset),
    .start (start),
    .div   (bus.ALUctl == ALU_DIVU),
    .a     (bus.A),
    .b     (bus.B),
    .done  (md_done),
    .hi    (md_hi),
    .lo    (md_lo)
  );
  // single-cycle ALU result and signed overflow for ADD/SUB
  always_comb begin
    sum = bus.A + bus.B;
    dif = bus.A - bus.B;
    res = '0;
    ovf = 1'b0;
    case (bus.ALUctl)
      ALU_AND:  res = bus.A & bus.B;
      ALU_OR:   res = bus.A | bus.B;
      ALU_ADD: begin
        res = sum;
        ovf = bus.A[WIDTH-1] == bus.B[WIDTH-1] && sum[WIDTH-1] != bus.A[WIDTH-1];
      end
      ALU_SUB: begin
        res = dif;
        ovf = bus.A[WIDTH-1] != bus.B[WIDTH-1] && dif[WIDTH-1] != bus.A[WIDTH-1];
      end
      ALU_SLT:  res = {{(WIDTH-1){1'b0}}, $signed(bus.A) < $signed(bus.B)};
      ALU_NOR:  res = ~(bus.A | bus.B);
      ALU_MFHI: res = hi_r;
      ALU_MFLO: res = lo_r;
      default:  res = '0;
    endcase
  end
  // next state: leave IDLE on a MULTU/DIVU accept, return when the iterator finishes
  always_comb begin
    nxt = state;
    nxt = state == ST_IDLE ? (start ? (bus.ALUctl == ALU_DIVU ? ST_DIV : ST_MUL) : ST_IDLE)
                           : (md_done ? ST_IDLE : state);
  end
  // state register
  always_ff @(posedge clk) begin
    state <= reset ? ST_IDLE : nxt;
  end
  // result registers and HI/LO commit
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.ALUOut    <= '0;
      bus.Zero      <= 1'b1;
      bus.Overflow  <= 1'b0;
      hi_r          <= '0;
      lo_r          <= '0;
    end else begin
      bus.out_valid <= (accept && !start) || md_done;
      if (md_done) begin
        hi_r         <= md_hi;
        lo_r         <= md_lo;
        bus.ALUOut   <= md_lo;
        bus.Zero     <= md_lo == '0;
        bus.Overflow <= 1'b0;
      end else if (accept && !start) begin
        bus.ALUOut   <= res;
        bus.Zero     <= res == '0;
        bus.Overflow <= ovf;
      end
    end
  end
endmodule

// File: tb/tb_mips_alu_md.sv
// tb_mips_alu_md: table-driven scoreboard bench for the registered MIPS ALU with mul/div
module tb_mips_alu_md;
  import mips_alu_pkg::*;
  localparam int W = 32;
  localparam int NV = 19;
  logic clk = 1'b0;
  logic reset = 1'b1;
  mips_alu_md_if #(.WIDTH(W)) bus ();
  mips_alu_md #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [3:0]   ctl;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] out;
    logic         z;
    logic         ov;
    int           lat;
    int           acc;
  } vec_t;
  vec_t q[$];
  vec_t cur;
  vec_t tv[NV];
  int cyc = 0;
  int checks = 0;
  int passes = 0;
  always @(posedge clk) cyc++;
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask
  // scoreboard: pop and compare on out_valid, push the pending expectation on accept
  always @(negedge clk) begin : mon
    vec_t e;
    if (reset) q.delete();
    else begin
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_out_valid: got ALUOut %0h expected no result", bus.ALUOut);
        end else begin
          e = q.pop_front();
          chk($sformatf("result ctl=%0d {ALUOut,Zero,Overflow}", e.ctl),
              64'({bus.ALUOut, bus.Zero, bus.Overflow}), 64'({e.out, e.z, e.ov}));
          chk($sformatf("latency ctl=%0d", e.ctl), 64'(cyc - e.acc), 64'(e.lat));
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        e = cur;
        e.acc = cyc;
        q.push_back(e);
      end
    end
  end
  task automatic issue(input logic [3:0] ctl, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] out, input logic z, input logic ov, input int lat,
                       output int acc);
    bit got = 1'b0;
    int n = 0;
    acc = -1;
    cur = '{ctl, a, b, out, z, ov, lat, 0};
    bus.ALUctl = ctl;
    bus.A = a;
    bus.B = b;
    bus.in_valid = 1'b1;
    while (!got && n < 200) begin
      @(negedge clk);
      got = bus.in_ready;
      acc = cyc;
      n++;
      @(posedge clk);
      #1;
    end
    if (!got) begin
      checks++;
      $display("FAIL accept_timeout ctl=%0d: got no accept expected accept within 200 cycles", ctl);
    end
    bus.in_valid = 1'b0;
  endtask
  initial begin
    int acc;
    int acc_div;
    int acc_add;
    int low_cnt;
    int busy_cnt;
    int n;
    bus.in_valid = 1'b0;
    bus.ALUctl = 4'd0;
    bus.A = '0;
    bus.B = '0;
    tv[0]  = '{ALU_AND,   32'h55555555, 32'hAAAAAAAB, 32'h00000001, 1'b0, 1'b0, 1,  0};
    tv[1]  = '{ALU_OR,    32'h55555555, 32'hAAAAAAAB, 32'hFFFFFFFF, 1'b0, 1'b0, 1,  0};
    tv[2]  = '{ALU_ADD,   32'h55555555, 32'hAAAAAAAB, 32'h00000000, 1'b1, 1'b0, 1,  0};
    tv[3]  = '{ALU_SUB,   32'h55555555, 32'hAAAAAAAB, 32'hAAAAAAAA, 1'b0, 1'b1, 1,  0};
    tv[4]  = '{ALU_SLT,   32'h55555555, 32'hAAAAAAAB, 32'h00000000, 1'b1, 1'b0, 1,  0};
    tv[5]  = '{ALU_NOR,   32'h55555555, 32'hAAAAAAAB, 32'h00000000, 1'b1, 1'b0, 1,  0};
    tv[6]  = '{ALU_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 1'b0, 1'b0, 33, 0};
    tv[7]  = '{ALU_MFHI,  32'h00000000, 32'h00000000, 32'h00000001, 1'b0, 1'b0, 1,  0};
    tv[8]  = '{ALU_MFLO,  32'h00000000, 32'h00000000, 32'hFFFFFFFE, 1'b0, 1'b0, 1,  0};
    tv[9]  = '{ALU_DIVU,  32'd100,      32'd7,        32'h0000000E, 1'b0, 1'b0, 33, 0};
    tv[10] = '{ALU_MFHI,  32'h00000000, 32'h00000000, 32'h00000002, 1'b0, 1'b0, 1,  0};
    tv[11] = '{ALU_DIVU,  32'h00001234, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0, 33, 0};
    tv[12] = '{ALU_MFHI,  32'h00000000, 32'h00000000, 32'h00001234, 1'b0, 1'b0, 1,  0};
    tv[13] = '{4'd15,     32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b1, 1'b0, 1,  0};
    tv[14] = '{ALU_MFLO,  32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1,  0};
    tv[15] = '{ALU_ADD,   32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1,  0};
    tv[16] = '{ALU_SUB,   32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, 1,  0};
    tv[17] = '{ALU_SLT,   32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1,  0};
    tv[18] = '{4'd5,      32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1,  0};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset in_ready", 64'(bus.in_ready), 64'(0));
    chk("reset out_valid", 64'(bus.out_valid), 64'(0));
    chk("reset ALUOut", 64'(bus.ALUOut), 64'(0));
    chk("reset Zero", 64'(bus.Zero), 64'(1));
    chk("reset Overflow", 64'(bus.Overflow), 64'(0));
    chk("reset busy", 64'(bus.busy), 64'(0));
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < NV; i++)
      issue(tv[i].ctl, tv[i].a, tv[i].b, tv[i].out, tv[i].z, tv[i].ov, tv[i].lat, acc);
    issue(ALU_MULTU, 32'h0000FFFF, 32'h00010001, 32'hFFFFFFFF, 1'b0, 1'b0, 33, acc);
    bus.A = $urandom;
    bus.B = $urandom;
    low_cnt = 0;
    busy_cnt = 0;
    n = 0;
    do begin
      @(negedge clk);
      if (!bus.in_ready) low_cnt++;
      if (bus.busy) busy_cnt++;
      n++;
    end while (!bus.in_ready && n < 100);
    chk("multu in_ready low cycles", 64'(low_cnt), 64'(32));
    chk("multu busy cycles", 64'(busy_cnt), 64'(32));
    @(posedge clk);
    #1;
    issue(ALU_MFHI, '0, '0, 32'h00000000, 1'b1, 1'b0, 1, acc);
    issue(ALU_DIVU, 32'd1000, 32'd10, 32'd100, 1'b0, 1'b0, 33, acc_div);
    issue(ALU_ADD, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0, 1, acc_add);
    chk("add held during divu accept delay", 64'(acc_add - acc_div), 64'(33));
    issue(ALU_MFHI, '0, '0, 32'h00000000, 1'b1, 1'b0, 1, acc);
    issue(ALU_MULTU, 32'h12345678, 32'd9, 32'hA3D70A38, 1'b0, 1'b0, 33, acc);
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("in_ready during reset", 64'(bus.in_ready), 64'(0));
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("post-reset in_ready", 64'(bus.in_ready), 64'(1));
    chk("post-reset busy", 64'(bus.busy), 64'(0));
    chk("post-reset outputs {out_valid,ALUOut,Zero,Overflow}",
        64'({bus.out_valid, bus.ALUOut, bus.Zero, bus.Overflow}), 64'({1'b0, 32'h0, 1'b1, 1'b0}));
    repeat (40) @(negedge clk);
    @(posedge clk);
    #1;
    issue(ALU_MFHI, '0, '0, 32'h00000000, 1'b1, 1'b0, 1, acc);
    issue(ALU_MFLO, '0, '0, 32'h00000000, 1'b1, 1'b0, 1, acc);
    n = 0;
    while (q.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      $display("FAIL drain: got %0d results outstanding expected 0", q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/mips_alu_md.md
# mips_alu_md

Parametrised, handshaked successor to the combinational MIPS ALU. It keeps the existing ALUctl encodings (AND/OR/ADD/SUB/SLT/NOR), registers every result with one-cycle latency, adds a signed-overflow flag, and adds an iterative unsigned multiply/divide unit with HI/LO registers and MFHI/MFLO reads. It sits in the EX stage of the multi-cycle datapath; the controller stalls on `in_ready` low.

## Interface
- `WIDTH`, 32, operand and result width; must be ≥4.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operation request.
- `in_ready`  out  1  high when the block can accept an operation.
- `ALUctl`  in  4  operation code.
- `A`, `B`  in  WIDTH  operands.
- `out_valid`  out  1  one-cycle pulse marking a new result.
- `ALUOut`  out  WIDTH  result.
- `Zero`  out  1  `ALUOut == 0`.
- `Overflow`  out  1  two's-complement overflow of ADD or SUB; 0 for every other op.
- `busy`  out  1  a multiply or divide is in progress.

## Operation
- An operation is accepted on `in_valid && in_ready`. There is no output backpressure.
- `ALUOut`, `Zero` and `Overflow` are registered and hold their values until the next `out_valid`.
- Opcodes:
  - 0 AND, 1 OR, 2 ADD, 6 SUB.
  - 7 SLT: signed compare; `ALUOut` is 1 or 0.
  - 12 NOR.
  - 3 MULTU: `{HI,LO} = A*B` (unsigned, 2·WIDTH bits); `ALUOut = LO`.
  - 4 DIVU: `LO = A/B`, `HI = A%B` (unsigned); `ALUOut = LO`.
  - 8 MFHI: `ALUOut = HI`.
  - 9 MFLO: `ALUOut = LO`.
  - Any other code: `ALUOut = 0`, `Zero = 1`, `Overflow = 0`; HI/LO unchanged.
- ADD/SUB wrap modulo 2^WIDTH. `Overflow` is set when the operand signs make the true result unrepresentable.
- DIVU by zero: `LO` = all ones, `HI = A`. It takes the full iterative latency; there is no fast path.
- FSM states:
  - IDLE: `in_ready = 1`. MULTU or DIVU goes to MUL or DIV; every other op stays in IDLE.
  - MUL: shift-add, one bit per cycle; WIDTH iterations, then IDLE.
  - DIV: restoring division, one quotient bit per cycle; WIDTH iterations, then IDLE.
- An iteration counter of ⌈log2 WIDTH⌉+1 bits counts down from WIDTH-1. The last iteration is at count 0.
- Operands are latched at accept, so `A`/`B` may change freely while `busy`.
- HI/LO are written only on MULTU/DIVU completion. MFHI/MFLO read the committed value.

## Timing
- Single-cycle ops: accepted in cycle N, `out_valid` in cycle N+1. Back-to-back accepts give a result every cycle.
- MULTU/DIVU:
  - Accepted in cycle N.
  - `busy` and `!in_ready` during cycles N+1 … N+WIDTH.
  - `out_valid` pulses with the final registered result in cycle N+WIDTH+1. HI/LO update on the same edge.
  - `in_ready` returns high in cycle N+WIDTH+1, so a new op can be accepted in that cycle.
- MFHI/MFLO accepted in the same cycle as MULTU/DIVU completion (`out_valid`) reads the new HI/LO.
- `in_ready` is forced to 0 while `reset` is high.
- Reset values: `out_valid` 0, `ALUOut` 0, `Zero` 1, `Overflow` 0, `busy` 0, HI 0, LO 0, state IDLE.
- Reset mid-multiply/divide:
  - The operation is abandoned and produces no `out_valid`.
  - HI/LO are cleared.
  - `in_ready` is 1 in the first cycle after `reset` falls.

## Structure
- Package `mips_alu_pkg`:
  - ALUctl localparams: `ALU_AND=0, ALU_OR=1, ALU_ADD=2, ALU_MULTU=3, ALU_DIVU=4, ALU_SUB=6, ALU_SLT=7, ALU_MFHI=8, ALU_MFLO=9, ALU_NOR=12`.
  - FSM state enum: `ST_IDLE, ST_MUL, ST_DIV`.
- Sub-module `mips_muldiv_iter`:
  - Parametrised by WIDTH.
  - Owns the shift registers, the counter and the start/done handshake.
  - Returns `{hi, lo}`.
- Top level owns the combinational ALU, the result registers, HI/LO and the FSM.

## Test plan
All values assume WIDTH=32.
- A=55555555, B=AAAAAAAB, ALUctl 0,1,2,6,7 on consecutive cycles → one result per cycle:
  - AND: 00000001.
  - OR: FFFFFFFF.
  - ADD: 00000000, Zero=1, Overflow=0.
  - SUB: AAAAAAAA, Overflow=1.
  - SLT: 00000000.
- MULTU A=FFFFFFFF, B=2, then MFHI, MFLO:
  - `out_valid` exactly 33 cycles after accept; ALUOut=FFFFFFFE.
  - `in_ready` low for 32 cycles.
  - MFHI=00000001, MFLO=FFFFFFFE.
- DIVU 100/7 then MFHI → LO=0000000E, HI=00000002. DIVU 1234/0 → LO=FFFFFFFF, HI=00001234; latency is still 33 cycles.
- `in_valid` held high with ADD during a DIVU → no accept while `busy`; the ADD is accepted in the completion cycle, and its result appears in the following cycle.
- Reset asserted 10 cycles into a MULTU → no `out_valid`; outputs return to reset values; MFHI after reset returns 00000000 with Zero=1.
- ALUctl=15 → ALUOut=0, Zero=1; HI/LO unchanged (checked via MFLO).
